ifu_fetch: RTL and testbench

- Instruction fetch stage for the RV64 core; sits directly upstream of the opcode decoder.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request with a valid-only response.
- Buffers returned instructions in a 2-entry FIFO and presents {inst, pc} to decode over valid/ready.
- Handles control-flow redirects from the branch unit, including flush and discard of stale in-flight responses.

---
 rtl/ifu_fetch_if.sv | 30 +++
 rtl/ifu_fetch.sv | 114 +++++++++++
 tb/tb_ifu_fetch.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, branch redirect and the decode-side output.
// master is the fetch unit, slave is the surrounding memory/branch/decode environment.
interface ifu_fetch_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// RV64 fetch stage: one outstanding imem request, 2-entry output FIFO, redirect with stale-response discard.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000),
    parameter int              INST_W   = 32
) (
    input  logic clk,
    input  logic rst,
    ifu_fetch_if.master bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt
`endif
);
    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   req_pc;
    logic              inflight;
    logic              discard;
    logic [1:0]        count;
    logic [INST_W-1:0] inst_q [2];
    logic [PC_W-1:0]   pc_q   [2];

    logic req_valid;
    logic req_fire;
    logic resp_acc;
    logic pop;
    logic push;
    logic wr_slot;

    always_comb begin
        req_valid = (state == S_REQ) && !inflight
                    && ((count + {1'b0, inflight}) < 2'd2) && !rst;
        req_fire  = req_valid && bus.imem_req_ready;
        resp_acc  = bus.imem_resp_valid && inflight;
        pop       = (count != 2'd0) && bus.out_ready;
        // A response that coincides with a redirect belongs to the old path.
        push      = resp_acc && !discard && !bus.redirect_valid;
        // Slot 1 only when the head stays occupied after this cycle's pop.
        wr_slot   = (count == 2'd2) || ((count == 2'd1) && !pop);
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.out_valid      = (count != 2'd0);
    assign bus.out_inst       = inst_q[0];
    assign bus.out_pc         = pc_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
            count    <= 2'd0;
            inst_q[0] <= '0;
            inst_q[1] <= '0;
            pc_q[0]   <= '0;
            pc_q[1]   <= '0;
        end else begin
            if (req_fire) begin
                inflight <= 1'b1;
                req_pc   <= pc;
            end else if (resp_acc) begin
                inflight <= 1'b0;
            end

            if (bus.redirect_valid) begin
                pc      <= bus.redirect_pc;
                count   <= 2'd0;
                state   <= S_REQ;
                // Stays set across back-to-back redirects until a response is consumed.
                discard <= req_fire || (inflight && !bus.imem_resp_valid);
            end else begin
                if (req_fire) begin
                    pc    <= pc + PC_W'(4);
                    state <= S_WAIT;
                end else if (resp_acc) begin
                    state   <= S_REQ;
                    discard <= 1'b0;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end

            if (pop && (count == 2'd2)) begin
                inst_q[0] <= inst_q[1];
                pc_q[0]   <= pc_q[1];
            end
            if (push) begin
                inst_q[wr_slot] <= bus.imem_resp_data;
                pc_q[wr_slot]   <= req_pc;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push)
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (count == 2'd0)
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: inline memory model, pop scoreboard, redirect and reset corner cases.
module tb_ifu_fetch;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   n_pop;
    int   target;
    logic [63:0] exp_pc;

    logic        pend_vld;
    logic [63:0] pend_addr;
    int          pend_dly;
    int          mem_dly;
    bit          rand_dly;
    bit          rand_ready;
    bit          rand_out;
    bit          last_fire;
    bit          found;

    ifu_fetch_if #(.PC_W(64), .INST_W(32)) bus ();

`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ifu_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h00A5_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes, advance, then model memory and drive next-cycle inputs.
    task automatic tick();
        logic        fire;
        logic        popped;
        logic [63:0] a;
        #1;
        fire   = bus.imem_req_valid && bus.imem_req_ready;
        a      = bus.imem_req_addr;
        popped = bus.out_valid && bus.out_ready;
        if (popped) begin
            chk("sb_pc", bus.out_pc, exp_pc);
            chk("sb_inst", {32'b0, bus.out_inst}, {32'b0, inst_of(exp_pc)});
            exp_pc = exp_pc + 64'd4;
            n_pop++;
        end
        last_fire = fire;
        @(posedge clk);
        @(negedge clk);
        if (bus.imem_resp_valid) begin
            bus.imem_resp_valid = 1'b0;
            pend_vld = 1'b0;
        end
        if (fire) begin
            pend_vld  = 1'b1;
            pend_addr = a;
            pend_dly  = rand_dly ? int'($urandom_range(5, 1)) : mem_dly;
        end
        if (pend_vld && !bus.imem_resp_valid) begin
            pend_dly--;
            if (pend_dly == 0) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = inst_of(pend_addr);
            end
        end
        if (rand_ready) bus.imem_req_ready = ($urandom_range(1, 0) != 0);
        if (rand_out)   bus.out_ready      = ($urandom_range(3, 0) != 0);
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; n_pop = 0;
        exp_pc = 64'h8000_0000;
        pend_vld = 1'b0; pend_addr = '0; pend_dly = 0;
        mem_dly = 1; rand_dly = 1'b0; rand_ready = 1'b0; rand_out = 1'b0;
        last_fire = 1'b0; found = 1'b0;
        rst = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b1;

        repeat (3) tick();
        chk("rst_req_valid", {63'b0, bus.imem_req_valid}, 64'd0);
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_out_inst", {32'b0, bus.out_inst}, 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);

        // Sequential fetch from the reset PC.
        rst = 1'b0;
        #1;
        chk("c0_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);
        chk("c0_addr", bus.imem_req_addr, 64'h8000_0000);
        tick();
        chk("c1_req_valid", {63'b0, bus.imem_req_valid}, 64'd0);
        chk("c1_out_valid", {63'b0, bus.out_valid}, 64'd0);
        tick();
        chk("c2_out_valid", {63'b0, bus.out_valid}, 64'd1);
        chk("c2_out_pc", bus.out_pc, 64'h8000_0000);
        chk("c2_addr", bus.imem_req_addr, 64'h8000_0004);
        tick();
        chk("c3_out_valid", {63'b0, bus.out_valid}, 64'd0);
        tick();
        chk("c4_out_pc", bus.out_pc, 64'h8000_0004);
        chk("c4_addr", bus.imem_req_addr, 64'h8000_0008);

        // Decode stalls: FIFO fills to two and fetching stops.
        bus.out_ready = 1'b0;
        repeat (10) tick();
        chk("full_req_valid", {63'b0, bus.imem_req_valid}, 64'd0);
        chk("full_out_pc", bus.out_pc, 64'h8000_0004);
        bus.out_ready = 1'b1;
        tick();
        chk("rel_out_pc", bus.out_pc, 64'h8000_0008);
        chk("rel_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);
        chk("rel_addr", bus.imem_req_addr, 64'h8000_000C);
        tick();
        chk("drain_out_valid", {63'b0, bus.out_valid}, 64'd0);
        tick();
        chk("e2_out_pc", bus.out_pc, 64'h8000_000C);
        chk("e2_addr", bus.imem_req_addr, 64'h8000_0010);

        // Redirect while the 8000_0010 request is outstanding.
        mem_dly = 3;
        tick();
        chk("e3_req_valid", {63'b0, bus.imem_req_valid}, 64'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0100;
        exp_pc             = 64'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        chk("e4_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("e4_req_valid", {63'b0, bus.imem_req_valid}, 64'd0);
        tick();
        chk("e5_stale_resp", {63'b0, bus.imem_resp_valid}, 64'd1);
        chk("e5_req_valid", {63'b0, bus.imem_req_valid}, 64'd0);
        tick();
        chk("e6_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("e6_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);
        chk("e6_addr", bus.imem_req_addr, 64'h8000_0100);
        mem_dly = 1;
        tick();
        chk("e7_out_valid", {63'b0, bus.out_valid}, 64'd0);
        tick();
        chk("e8_out_pc", bus.out_pc, 64'h8000_0100);
        chk("e8_addr", bus.imem_req_addr, 64'h8000_0104);

        // Redirect coinciding with a response and a pop.
        bus.out_ready = 1'b0;
        tick();
        chk("e9_resp", {63'b0, bus.imem_resp_valid}, 64'd1);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0200;
        tick();
        bus.redirect_valid = 1'b0;
        exp_pc = 64'h8000_0200;
        chk("e10_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("e10_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);
        chk("e10_addr", bus.imem_req_addr, 64'h8000_0200);
        tick();
        tick();
        chk("e12_out_valid", {63'b0, bus.out_valid}, 64'd1);
        chk("e12_out_pc", bus.out_pc, 64'h8000_0200);

        // Random memory readiness and latency over 1000 instructions.
        rand_ready = 1'b1; rand_dly = 1'b1; rand_out = 1'b1;
        target = n_pop + 1000;
        for (int i = 0; i < 40000; i++) begin
            tick();
            if (n_pop >= target) break;
        end
        chk("rand_pops_done", {63'b0, (n_pop >= target)}, 64'd1);

        // Reset while a request is in flight; the late response must be ignored.
        rand_ready = 1'b0; rand_dly = 1'b0; rand_out = 1'b0;
        bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1; mem_dly = 3;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_fire) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_fire_found", {63'b0, found}, 64'd1);
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("f1_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("f1_out_pc", bus.out_pc, 64'd0);
        chk("f1_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);
        chk("f1_addr", bus.imem_req_addr, 64'h8000_0000);
`ifdef IFU_PERF_CNT_EN
        chk("f1_perf_fetch", perf_fetch_cnt, 64'd0);
        chk("f1_perf_stall", perf_stall_cnt, 64'd0);
`endif
        tick();
        chk("f2_late_resp", {63'b0, bus.imem_resp_valid}, 64'd1);
        chk("f2_out_valid", {63'b0, bus.out_valid}, 64'd0);
`ifdef IFU_PERF_CNT_EN
        chk("f2_perf_stall", perf_stall_cnt, 64'd1);
`endif
        tick();
        chk("f3_out_valid", {63'b0, bus.out_valid}, 64'd0);
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        mem_dly            = 1;
        exp_pc             = 64'h8000_0000;
        tick();
        chk("f4_out_valid", {63'b0, bus.out_valid}, 64'd0);
        tick();
        chk("f5_out_valid", {63'b0, bus.out_valid}, 64'd1);
        chk("f5_out_pc", bus.out_pc, 64'h8000_0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
